// File: rtl/stage_sequencer_pkg.sv
// Shared CPU package: sequencer state encoding and instruction opcodes.
// Also imported by the control unit, so the opcode constants live here
// rather than inside the sequencer.
//
// Contents:
//   seq_state_t      - instruction phase state encoding
//   OP_*             - opcode constants (instr[31:28])
//   opcode_of()      - extracts the opcode field from an instruction word
//   reads_mem()      - readMem is a real memory phase for this opcode
//   writes_mem()     - writeBack is a real memory phase for this opcode
package stage_sequencer_pkg;

  typedef enum logic [3:0] {
    F_REQ  = 4'd0,
    F_WAIT = 4'd1,
    REGS   = 4'd2,
    M_REQ  = 4'd3,
    M_WAIT = 4'd4,
    M_ONE  = 4'd5,
    W_REQ  = 4'd6,
    W_WAIT = 4'd7,
    W_ONE  = 4'd8
  } seq_state_t;

  localparam logic [3:0] OP_READ  = 4'b1110;
  localparam logic [3:0] OP_WRITE = 4'b1101;
  localparam logic [3:0] OP_COPY  = 4'b1100;
  localparam logic [3:0] OP_RETI  = 4'b0001;
  // HALT needs no sequencer support: the control unit jumps to the current
  // address and fetch proceeds as usual.
  localparam logic [3:0] OP_HALT  = 4'b1111;

  function automatic logic [3:0] opcode_of(input logic [31:0] word);
    return word[31:28];
  endfunction

  function automatic logic reads_mem(input logic [3:0] op);
    return (op == OP_READ) || (op == OP_COPY);
  endfunction

  function automatic logic writes_mem(input logic [3:0] op);
    return (op == OP_WRITE) || (op == OP_COPY);
  endfunction

endpackage

// File: rtl/stage_sequencer_irq_latch.sv
// irq_latch: interrupt edge detector, pending flag and in-ISR flag.
//
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   irq         - level interrupt request, synchronous to clk
//   last_wb     - current cycle is the last writeBack cycle of an instruction
//   is_reti     - the current instruction is RETI
//   int_take    - one-cycle pulse: PC enters the interrupt vector
//   pending     - an irq rising edge is waiting to be taken
//   in_isr      - an interrupt service routine is active
module irq_latch (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic last_wb,
  input  logic is_reti,
  output logic int_take,
  output logic pending,
  output logic in_isr
);

  logic irq_prev;
  logic irq_rise;

  assign irq_rise = irq & ~irq_prev;

  // RETI never takes an interrupt in its own last cycle; a pending request
  // waits for the end of the following instruction.
  assign int_take = last_wb & pending & ~in_isr & ~is_reti;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev <= 1'b0;
      pending  <= 1'b0;
      in_isr   <= 1'b0;
    end else begin
      irq_prev <= irq;
      // A fresh edge coinciding with int_take re-arms pending immediately.
      if (int_take) begin
        pending <= irq_rise;
      end else if (irq_rise) begin
        pending <= 1'b1;
      end
      if (int_take) begin
        in_isr <= 1'b1;
      end else if (last_wb && is_reti) begin
        in_isr <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: instruction phase sequencer for the CPU control unit.
// Steps every instruction through fetch -> getRegs -> readMem -> writeBack,
// waiting on the memory controller's busy flag in the memory phases, and
// produces PC advance / interrupt entry pulses at the end of writeBack.
//
// Memory handshake: a *_REQ state waits for busy=1 (request accepted), the
// following *_WAIT state waits for busy=0 (data/operation complete).
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-low reset
//   busy       - memory controller busy flag
//   q          - memory read data (instruction captured on F_WAIT exit)
//   irq        - level interrupt request, synchronous to clk
//   fetch, getRegs, readMem, writeBack - one-hot phase levels
//   instr      - instruction register
//   pc_advance - one-cycle pulse in the last writeBack cycle
//   int_take   - one-cycle pulse: enter interrupt vector (wins over pc_advance)
//   in_isr     - interrupt service routine active
//   state_dbg  - current sequencer state (observation only)
module stage_sequencer
  import stage_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        busy,
  input  logic [31:0] q,
  input  logic        irq,
  output logic        fetch,
  output logic        getRegs,
  output logic        readMem,
  output logic        writeBack,
  output logic [31:0] instr,
  output logic        pc_advance,
  output logic        int_take,
  output logic        in_isr,
  output seq_state_t  state_dbg
);

  seq_state_t state;
  seq_state_t state_next;
  logic [3:0] opcode;
  logic       instr_load;
  logic       last_wb;
  logic       is_reti;
  logic       pending;

  assign opcode  = opcode_of(instr);
  assign is_reti = (opcode == OP_RETI);

  // Instruction word is only taken on the F_WAIT exit edge, so q traffic
  // during READ/COPY data phases never disturbs decode.
  assign instr_load = (state == F_WAIT) && !busy;

  assign last_wb = (state == W_ONE) || ((state == W_WAIT) && !busy);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= F_REQ;
      instr <= 32'd0;
    end else begin
      state <= state_next;
      if (instr_load) begin
        instr <= q;
      end
    end
  end

  // busy is ignored in REGS, M_ONE and W_ONE: they always last one cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      F_REQ:  if (busy)  state_next = F_WAIT;
      F_WAIT: if (!busy) state_next = REGS;
      REGS:   state_next = reads_mem(opcode) ? M_REQ : M_ONE;
      M_REQ:  if (busy)  state_next = M_WAIT;
      M_WAIT: if (!busy) state_next = writes_mem(opcode) ? W_REQ : W_ONE;
      M_ONE:  state_next = writes_mem(opcode) ? W_REQ : W_ONE;
      W_REQ:  if (busy)  state_next = W_WAIT;
      W_WAIT: if (!busy) state_next = F_REQ;
      W_ONE:  state_next = F_REQ;
      default: state_next = F_REQ;
    endcase
  end

  always_comb begin
    fetch     = 1'b0;
    getRegs   = 1'b0;
    readMem   = 1'b0;
    writeBack = 1'b0;
    unique case (state)
      F_REQ, F_WAIT:        fetch     = 1'b1;
      REGS:                 getRegs   = 1'b1;
      M_REQ, M_WAIT, M_ONE: readMem   = 1'b1;
      W_REQ, W_WAIT, W_ONE: writeBack = 1'b1;
      default:              fetch     = 1'b1;
    endcase
  end

  // pc_advance fires even when int_take does; the PC gives int_take priority.
  assign pc_advance = last_wb;
  assign state_dbg  = state;

  irq_latch u_irq_latch (
    .clk      (clk),
    .reset    (reset),
    .irq      (irq),
    .last_wb  (last_wb),
    .is_reti  (is_reti),
    .int_take (int_take),
    .pending  (pending),
    .in_isr   (in_isr)
  );

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer: directed per-cycle vectors. Each vector
// drives inputs just after a rising edge and pushes the hand-computed
// outputs expected for that cycle; a monitor pops and compares on the
// falling edge.
//
// Expected word layout: {fetch, getRegs, readMem, writeBack,
//                        pc_advance, int_take, in_isr, instr[31:0]}
module tb_stage_sequencer;
  import stage_sequencer_pkg::*;

  localparam int W = 39;
  localparam logic [3:0]  P_F  = 4'b1000;
  localparam logic [3:0]  P_G  = 4'b0100;
  localparam logic [3:0]  P_M  = 4'b0010;
  localparam logic [3:0]  P_W  = 4'b0001;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [31:0] q;
  logic        irq;
  logic        fetch, getRegs, readMem, writeBack;
  logic [31:0] instr;
  logic        pc_advance, int_take, in_isr;
  seq_state_t  state_dbg;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks_total  = 0;
  int           checks_passed = 0;

  stage_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .busy       (busy),
    .q          (q),
    .irq        (irq),
    .fetch      (fetch),
    .getRegs    (getRegs),
    .readMem    (readMem),
    .writeBack  (writeBack),
    .instr      (instr),
    .pc_advance (pc_advance),
    .int_take   (int_take),
    .in_isr     (in_isr),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    reset = 1'b0;
    busy  = 1'b0;
    q     = 32'd0;
    irq   = 1'b0;
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic b, input logic [31:0] qq,
                     input logic ir, input logic [3:0] ph, input logic pa,
                     input logic it, input logic isr, input logic [31:0] ins,
                     input string nm);
    @(posedge clk);
    #1;
    reset = r;
    busy  = b;
    q     = qq;
    irq   = ir;
    exp_q.push_back({ph, pa, it, isr, ins});
    name_q.push_back(nm);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] act_v;
      string        nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {fetch, getRegs, readMem, writeBack, pc_advance, int_take,
               in_isr, instr};
      checks_total++;
      if (act_v === exp_v) begin
        checks_passed++;
      end else begin
        $display("FAIL %s: got ph=%b pa=%b it=%b isr=%b instr=%h (state %s) expected ph=%b pa=%b it=%b isr=%b instr=%h",
                 nm, act_v[38:35], act_v[34], act_v[33], act_v[32], act_v[31:0],
                 state_dbg.name(), exp_v[38:35], exp_v[34], exp_v[33],
                 exp_v[32], exp_v[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    //  rst busy q            irq phase pa it isr instr
    // Reset
    cyc(0, 0, JUNK,         0, P_F, 0, 0, 0, 32'h0,         "rst0");
    cyc(0, 1, JUNK,         0, P_F, 0, 0, 0, 32'h0,         "rst1");
    cyc(1, 0, JUNK,         0, P_F, 0, 0, 0, 32'h0,         "rst_release");

    // ARITH, busy high two cycles in fetch
    cyc(1, 1, JUNK,         0, P_F, 0, 0, 0, 32'h0,         "arith_freq");
    cyc(1, 1, JUNK,         0, P_F, 0, 0, 0, 32'h0,         "arith_fwait1");
    cyc(1, 0, 32'h0123_4567,0, P_F, 0, 0, 0, 32'h0,         "arith_fwait2");
    cyc(1, 0, JUNK,         0, P_G, 0, 0, 0, 32'h0123_4567, "arith_regs");
    cyc(1, 0, JUNK,         0, P_M, 0, 0, 0, 32'h0123_4567, "arith_mone");
    cyc(1, 0, JUNK,         0, P_W, 1, 0, 0, 32'h0123_4567, "arith_wone");

    // READ, busy high three cycles in readMem, q keeps changing
    cyc(1, 1, JUNK,         0, P_F, 0, 0, 0, 32'h0123_4567, "read_freq");
    cyc(1, 0, 32'hE000_0000,0, P_F, 0, 0, 0, 32'h0123_4567, "read_fwait");
    cyc(1, 1, JUNK,         0, P_G, 0, 0, 0, 32'hE000_0000, "read_regs_glitch");
    cyc(1, 1, 32'h1111_1111,0, P_M, 0, 0, 0, 32'hE000_0000, "read_mreq");
    cyc(1, 1, 32'h2222_2222,0, P_M, 0, 0, 0, 32'hE000_0000, "read_mwait1");
    cyc(1, 1, 32'h3333_3333,0, P_M, 0, 0, 0, 32'hE000_0000, "read_mwait2");
    cyc(1, 0, 32'h4444_4444,0, P_M, 0, 0, 0, 32'hE000_0000, "read_mwait3");
    cyc(1, 1, JUNK,         0, P_W, 1, 0, 0, 32'hE000_0000, "read_wone_glitch");

    // COPY: handshakes in fetch, readMem and writeBack
    cyc(1, 1, JUNK,         0, P_F, 0, 0, 0, 32'hE000_0000, "copy_freq");
    cyc(1, 0, 32'hC000_00AA,0, P_F, 0, 0, 0, 32'hE000_0000, "copy_fwait");
    cyc(1, 0, JUNK,         0, P_G, 0, 0, 0, 32'hC000_00AA, "copy_regs");
    cyc(1, 0, JUNK,         0, P_M, 0, 0, 0, 32'hC000_00AA, "copy_mreq_hold");
    cyc(1, 1, JUNK,         0, P_M, 0, 0, 0, 32'hC000_00AA, "copy_mreq");
    cyc(1, 0, JUNK,         0, P_M, 0, 0, 0, 32'hC000_00AA, "copy_mwait");
    cyc(1, 1, JUNK,         0, P_W, 0, 0, 0, 32'hC000_00AA, "copy_wreq");
    cyc(1, 1, JUNK,         0, P_W, 0, 0, 0, 32'hC000_00AA, "copy_wwait1");
    cyc(1, 0, JUNK,         0, P_W, 1, 0, 0, 32'hC000_00AA, "copy_wwait2");

    // HALT: fetch proceeds normally
    cyc(1, 1, JUNK,         0, P_F, 0, 0, 0, 32'hC000_00AA, "halt_freq");
    cyc(1, 0, 32'hF000_0000,0, P_F, 0, 0, 0, 32'hC000_00AA, "halt_fwait");
    cyc(1, 0, JUNK,         0, P_G, 0, 0, 0, 32'hF000_0000, "halt_regs");
    cyc(1, 0, JUNK,         0, P_M, 0, 0, 0, 32'hF000_0000, "halt_mone");
    cyc(1, 0, JUNK,         0, P_W, 1, 0, 0, 32'hF000_0000, "halt_wone");

    // irq rises during REGS of an ARITH instruction
    cyc(1, 1, JUNK,         0, P_F, 0, 0, 0, 32'hF000_0000, "irq_freq");
    cyc(1, 0, 32'h2000_0001,0, P_F, 0, 0, 0, 32'hF000_0000, "irq_fwait");
    cyc(1, 0, JUNK,         1, P_G, 0, 0, 0, 32'h2000_0001, "irq_regs");
    cyc(1, 0, JUNK,         1, P_M, 0, 0, 0, 32'h2000_0001, "irq_mone");
    cyc(1, 0, JUNK,         1, P_W, 1, 1, 0, 32'h2000_0001, "irq_take");
    // second irq edge inside the ISR stays pending
    cyc(1, 1, JUNK,         0, P_F, 0, 0, 1, 32'h2000_0001, "isr_freq");
    cyc(1, 0, 32'h3000_0000,1, P_F, 0, 0, 1, 32'h2000_0001, "isr_irq2");
    cyc(1, 0, JUNK,         1, P_G, 0, 0, 1, 32'h3000_0000, "isr_regs");
    cyc(1, 0, JUNK,         1, P_M, 0, 0, 1, 32'h3000_0000, "isr_mone");
    cyc(1, 0, JUNK,         1, P_W, 1, 0, 1, 32'h3000_0000, "isr_no_take");

    // RETI with a request pending: no take in the RETI cycle
    cyc(1, 1, JUNK,         0, P_F, 0, 0, 1, 32'h3000_0000, "reti_freq");
    cyc(1, 0, 32'h1000_0000,0, P_F, 0, 0, 1, 32'h3000_0000, "reti_fwait");
    cyc(1, 0, JUNK,         0, P_G, 0, 0, 1, 32'h1000_0000, "reti_regs");
    cyc(1, 0, JUNK,         0, P_M, 0, 0, 1, 32'h1000_0000, "reti_mone");
    cyc(1, 0, JUNK,         0, P_W, 1, 0, 1, 32'h1000_0000, "reti_wone");
    // next instruction takes the pending request
    cyc(1, 1, JUNK,         0, P_F, 0, 0, 0, 32'h1000_0000, "post_freq");
    cyc(1, 0, 32'h4000_0000,0, P_F, 0, 0, 0, 32'h1000_0000, "post_fwait");
    cyc(1, 0, JUNK,         0, P_G, 0, 0, 0, 32'h4000_0000, "post_regs");
    cyc(1, 0, JUNK,         0, P_M, 0, 0, 0, 32'h4000_0000, "post_mone");
    cyc(1, 0, JUNK,         0, P_W, 1, 1, 0, 32'h4000_0000, "post_take");

    // reset asserted during M_WAIT of a READ
    cyc(1, 1, JUNK,         0, P_F, 0, 0, 1, 32'h4000_0000, "mrst_freq");
    cyc(1, 0, 32'hE000_0010,0, P_F, 0, 0, 1, 32'h4000_0000, "mrst_fwait");
    cyc(1, 0, JUNK,         0, P_G, 0, 0, 1, 32'hE000_0010, "mrst_regs");
    cyc(1, 1, JUNK,         0, P_M, 0, 0, 1, 32'hE000_0010, "mrst_mreq");
    cyc(1, 1, JUNK,         0, P_M, 0, 0, 1, 32'hE000_0010, "mrst_mwait");
    cyc(0, 1, JUNK,         1, P_F, 0, 0, 0, 32'h0,         "mrst_assert");
    cyc(0, 0, JUNK,         0, P_F, 0, 0, 0, 32'h0,         "mrst_hold");
    cyc(1, 1, JUNK,         0, P_F, 0, 0, 0, 32'h0,         "mrst_release");
    cyc(1, 0, 32'h0000_0005,0, P_F, 0, 0, 0, 32'h0,         "mrst_fwait_after");
    cyc(1, 0, JUNK,         0, P_G, 0, 0, 0, 32'h0000_0005, "mrst_regs_after");

    // drain the scoreboard with a bounded wait
    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        checks_total++;
        $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
